read_pointer_empty: RTL and testbench

- Read-side pointer and empty-flag controller for the AsyncFIFO.
- Receives the gray-coded write pointer from the write clock domain and synchronizes it internally with a 2-flop chain.
- Maintains the binary and gray read pointers and drives the RAM read address.
- Produces registered empty, almost-empty and fill-count outputs in the read clock domain.

---
 rtl/read_pointer_empty.sv | 92 +++++++++
 tb/tb_read_pointer_empty.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/read_pointer_empty.sv
`default_nettype none
// ============================================================================
// Module   : read_pointer_empty
// Purpose  : AsyncFIFO read-side pointer, write-pointer synchronizer and
//            registered empty / almost-empty / fill-count flags.
// Revision : 1.0 - initial release
// ============================================================================
module read_pointer_empty #(
  parameter int address_size           = 3,
  parameter int almost_empty_threshold = 1
) (
  input  logic                    read_clk,
  input  logic                    read_reset,
  input  logic                    read_increment,
  input  logic [address_size:0]   write_pointer,
  output logic [address_size:0]   read_pointer,
  output logic [address_size-1:0] read_address,
  output logic                    read_empty,
  output logic                    read_almost_empty,
  output logic [address_size:0]   read_count
);

  localparam int PW = address_size + 1;
  localparam logic [PW:0] c_ae_threshold = (PW+1)'(almost_empty_threshold);

  logic [PW-1:0]           sync1_q;
  logic [PW-1:0]           sync2_q;
  logic [PW-1:0]           rbin_q;
  logic [PW-1:0]           rbin_d;
  logic [PW-1:0]           rgray_q;
  logic [PW-1:0]           rgray_d;
  logic [address_size-1:0] raddr_q;
  logic                    empty_q;
  logic                    empty_d;
  logic                    aempty_q;
  logic                    aempty_d;
  logic [PW-1:0]           count_q;
  logic [PW-1:0]           count_d;

  logic                    w_fire;
  logic [PW-1:0]           w_wbin;

  // Gray-to-binary: each binary bit is the XOR of all gray bits at and above it.
  for (genvar i = 0; i < PW; i++) begin : g_g2b
    assign w_wbin[i] = ^sync2_q[PW-1:i];
  end

  assign w_fire = read_increment & ~empty_q;

  always_comb begin
    rbin_d   = rbin_q;
    if (w_fire) begin
      rbin_d = rbin_q + 1'b1;
    end
    rgray_d  = rbin_d ^ (rbin_d >> 1);
    // Empty compares against the look-ahead pointer so the flag rises on the
    // same edge that consumes the last word.
    empty_d  = (rgray_d == sync2_q);
    count_d  = w_wbin - rbin_d;
    aempty_d = ({1'b0, count_d} <= c_ae_threshold);
  end

  always_ff @(posedge read_clk or posedge read_reset) begin
    if (read_reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      rbin_q   <= '0;
      rgray_q  <= '0;
      raddr_q  <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      count_q  <= '0;
    end else begin
      sync1_q  <= write_pointer;
      sync2_q  <= sync1_q;
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      raddr_q  <= rbin_d[address_size-1:0];
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      count_q  <= count_d;
    end
  end

  assign read_pointer      = rgray_q;
  assign read_address      = raddr_q;
  assign read_empty        = empty_q;
  assign read_almost_empty = aempty_q;
  assign read_count        = count_q;

endmodule
`default_nettype wire

// File: tb/tb_read_pointer_empty.sv
`default_nettype none
// ============================================================================
// Module   : tb_read_pointer_empty
// Purpose  : Directed self-checking bench for read_pointer_empty (depth 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_read_pointer_empty;

  logic       clk;
  logic       rst;
  logic       read_increment;
  logic [3:0] write_pointer;
  logic [3:0] read_pointer;
  logic [2:0] read_address;
  logic       read_empty;
  logic       read_almost_empty;
  logic [3:0] read_count;

  int tests_run;
  int tests_failed;

  read_pointer_empty #(
    .address_size           (3),
    .almost_empty_threshold (1)
  ) dut (
    .read_clk          (clk),
    .read_reset        (rst),
    .read_increment    (read_increment),
    .write_pointer     (write_pointer),
    .read_pointer      (read_pointer),
    .read_address      (read_address),
    .read_empty        (read_empty),
    .read_almost_empty (read_almost_empty),
    .read_count        (read_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] rp, input logic [2:0] ra,
                           input logic e, input logic ae, input logic [3:0] cnt);
    check({tag, ".read_pointer"},      {28'd0, read_pointer},      {28'd0, rp});
    check({tag, ".read_address"},      {29'd0, read_address},      {29'd0, ra});
    check({tag, ".read_empty"},        {31'd0, read_empty},        {31'd0, e});
    check({tag, ".read_almost_empty"}, {31'd0, read_almost_empty}, {31'd0, ae});
    check({tag, ".read_count"},        {28'd0, read_count},        {28'd0, cnt});
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst            = 1'b1;
    read_increment = 1'b1;
    write_pointer  = 4'b0000;

    // 1: reset state, reads while empty ignored
    tick(2);
    check_all("t1_in_reset", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0);
    rst = 1'b0;
    tick(3);
    check_all("t1_after_reset", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0);
    read_increment = 1'b0;

    // 2: one word, flags update on the third edge
    write_pointer = 4'b0001;
    tick(1);
    check("t2_edge1_empty", {31'd0, read_empty}, 32'd1);
    tick(1);
    check("t2_edge2_empty", {31'd0, read_empty}, 32'd1);
    tick(1);
    check_all("t2_edge3", 4'b0000, 3'd0, 1'b0, 1'b1, 4'd1);

    // 3: four words, then drain
    write_pointer = 4'b0110;
    tick(3);
    check_all("t3_fill4", 4'b0000, 3'd0, 1'b0, 1'b0, 4'd4);
    read_increment = 1'b1;
    tick(1);
    check_all("t3_rd1", 4'b0001, 3'd1, 1'b0, 1'b0, 4'd3);
    tick(1);
    check_all("t3_rd2", 4'b0011, 3'd2, 1'b0, 1'b0, 4'd2);
    tick(1);
    check_all("t3_rd3", 4'b0010, 3'd3, 1'b0, 1'b1, 4'd1);
    tick(1);
    check_all("t3_rd4", 4'b0110, 3'd4, 1'b1, 1'b1, 4'd0);

    // 4: read requests while empty are ignored
    tick(5);
    check_all("t4_underflow", 4'b0110, 3'd4, 1'b1, 1'b1, 4'd0);
    read_increment = 1'b0;

    // 5: wrap-around (binary 4 -> 12 -> 15 -> 0)
    write_pointer = 4'b1010;
    tick(3);
    check_all("t5_full8", 4'b0110, 3'd4, 1'b0, 1'b0, 4'd8);
    read_increment = 1'b1;
    tick(8);
    check_all("t5_drain8", 4'b1010, 3'd4, 1'b1, 1'b1, 4'd0);
    read_increment = 1'b0;
    write_pointer = 4'b1000;
    tick(3);
    check_all("t5_fill3", 4'b1010, 3'd4, 1'b0, 1'b0, 4'd3);
    read_increment = 1'b1;
    tick(3);
    check_all("t5_at15", 4'b1000, 3'd7, 1'b1, 1'b1, 4'd0);
    read_increment = 1'b0;
    write_pointer = 4'b0000;
    tick(3);
    check_all("t5_wrap_fill1", 4'b1000, 3'd7, 1'b0, 1'b1, 4'd1);
    read_increment = 1'b1;
    tick(1);
    check_all("t5_wrap_read", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0);
    read_increment = 1'b0;

    // 6: asynchronous reset mid-operation
    write_pointer = 4'b0010;
    tick(3);
    check_all("t6_fill3", 4'b0000, 3'd0, 1'b0, 1'b0, 4'd3);
    #3;
    rst = 1'b1;
    #1;
    check_all("t6_async_reset", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    check("t6_edge1_empty", {31'd0, read_empty}, 32'd1);
    tick(1);
    check("t6_edge2_empty", {31'd0, read_empty}, 32'd1);
    tick(1);
    check_all("t6_edge3", 4'b0000, 3'd0, 1'b0, 1'b0, 4'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
